// File: rtl/pass_rule_sequencer.sv
// pass_rule_sequencer: sequences one password-check transaction and reports a registered verdict
// Ports: clock/reset (async, active low); start, abort, en, last, data_in[7:0] in;
//        busy, done, check, err, length, vowel_cnt, cons_cnt, digit_cnt, sym_cnt out (all registered).
// Optional symbol rule: define PASS_SYMBOL_RULE_EN to count symbols and require sym_cnt >= MIN_SYMS.
module pass_rule_sequencer #(
  parameter int MIN_LEN = 8,
  parameter int MAX_LEN = 32,
  parameter int MIN_VOWELS = 1,
  parameter int MIN_CONS = 1,
  parameter int MIN_DIGITS = 1
`ifdef PASS_SYMBOL_RULE_EN
  , parameter int MIN_SYMS = 1
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       en,
  input  logic       last,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       check,
  output logic       err,
  output logic [5:0] length,
  output logic [5:0] vowel_cnt,
  output logic [5:0] cons_cnt,
  output logic [5:0] digit_cnt,
  output logic [5:0] sym_cnt
);
  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, REPORT} state_t;
  state_t state;
  logic [7:0] low;
  logic legal, is_alpha, is_vowel, is_cons, is_digit, accept, pass_ok;
  // Folding bit 5 maps upper-case letters onto lower-case for a single range test.
  assign low = data_in | 8'h20;
  assign legal = data_in >= 8'h20 && data_in <= 8'h7e;
  assign is_alpha = legal && low >= 8'h61 && low <= 8'h7a;
  assign is_vowel = is_alpha && (low == 8'h61 || low == 8'h65 || low == 8'h69 || low == 8'h6f || low == 8'h75);
  assign is_cons = is_alpha && !is_vowel;
  assign is_digit = data_in >= 8'h30 && data_in <= 8'h39;
  assign accept = legal && length < 6'(MAX_LEN);
`ifdef PASS_SYMBOL_RULE_EN
  logic is_sym;
  assign is_sym = legal && data_in != 8'h20 && !is_alpha && !is_digit;
  assign pass_ok = length >= 6'(MIN_LEN) && vowel_cnt >= 6'(MIN_VOWELS) && cons_cnt >= 6'(MIN_CONS) &&
                   digit_cnt >= 6'(MIN_DIGITS) && sym_cnt >= 6'(MIN_SYMS) && !err;
`else
  assign sym_cnt = '0;
  assign pass_ok = length >= 6'(MIN_LEN) && vowel_cnt >= 6'(MIN_VOWELS) && cons_cnt >= 6'(MIN_CONS) &&
                   digit_cnt >= 6'(MIN_DIGITS) && !err;
`endif
  // done and check are captured on the edge leaving REPORT, so done appears two edges after the last byte.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      check <= 1'b0;
      err <= 1'b0;
      length <= '0;
      vowel_cnt <= '0;
      cons_cnt <= '0;
      digit_cnt <= '0;
`ifdef PASS_SYMBOL_RULE_EN
      sym_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          busy <= 1'b1;
          check <= 1'b0;
          err <= 1'b0;
          length <= '0;
          vowel_cnt <= '0;
          cons_cnt <= '0;
          digit_cnt <= '0;
`ifdef PASS_SYMBOL_RULE_EN
          sym_cnt <= '0;
`endif
        end
        COLLECT: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          check <= 1'b0;
        end else if (en) begin
          if (accept) begin
            length <= length + 6'd1;
            vowel_cnt <= vowel_cnt + 6'(is_vowel);
            cons_cnt <= cons_cnt + 6'(is_cons);
            digit_cnt <= digit_cnt + 6'(is_digit);
`ifdef PASS_SYMBOL_RULE_EN
            sym_cnt <= sym_cnt + 6'(is_sym);
`endif
          end else err <= 1'b1;
          if (last) state <= EVAL;
        end
        EVAL: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          check <= 1'b0;
        end else state <= REPORT;
        REPORT: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          check <= pass_ok;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/pass_rule_sequencer.md
Name: pass_rule_sequencer

Overview:
- Controller that sequences one password-check transaction: accepts a start command, streams password bytes, classifies each byte, evaluates the rule set and reports a registered verdict.
- Sits between the byte source (keypad/UART front end) and the status outputs of the password-checker top level.
- Owns the length counter and the per-class counters that the top level's counter/register datapath provides only in raw form.

Parameters:
- MIN_LEN, 8, minimum accepted password length in bytes.
- MAX_LEN, 32, maximum storable length; legal range MIN_LEN..63.
- MIN_VOWELS, 1, minimum vowel count.
- MIN_CONS, 1, minimum consonant count.
- MIN_DIGITS, 1, minimum digit count.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a transaction; honoured only in IDLE.
- abort  input  1  cancel the transaction and return to IDLE, no verdict.
- en  input  1  data_in valid this cycle.
- last  input  1  qualifies en; marks the final byte.
- data_in  input  8  ASCII byte.
- busy  output  1  high in COLLECT, EVAL and REPORT.
- done  output  1  one-cycle pulse in REPORT.
- check  output  1  verdict, 1 = password accepted; held until next start.
- err  output  1  overflow or illegal byte seen in the current transaction.
- length  output  6  bytes accepted.
- vowel_cnt  output  6  count of a,e,i,o,u in either case.
- cons_cnt  output  6  count of letters that are not vowels.
- digit_cnt  output  6  count of '0'..'9'.
- sym_cnt  output  6  count of 0x21..0x2F, 0x3A..0x40, 0x5B..0x60 and 0x7B..0x7E; constant 0 without the macro.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs and counters are 0.
  - An in-flight transaction is discarded with no done pulse.
- State IDLE:
  - start=1: clear counters, err and check; go to COLLECT next edge.
  - en and last are ignored.
- State COLLECT (one byte per cycle with en=1):
  - Legal byte (0x20..0x7E) with length<MAX_LEN: length+1, plus the matching class counter +1.
  - Space (0x20) counts in length only.
  - Byte outside 0x20..0x7E: err=1, byte dropped.
  - Byte with length==MAX_LEN: err=1, byte dropped, no counter wraps.
  - en&last=1: the byte is processed as above, then go to EVAL.
  - last without en is ignored.
- State EVAL (1 cycle): compute the pass condition combinationally:
  - length>=MIN_LEN
  - vowel_cnt>=MIN_VOWELS
  - cons_cnt>=MIN_CONS
  - digit_cnt>=MIN_DIGITS
  - err==0
- State REPORT (1 cycle): check is registered with the pass condition and done=1; go to IDLE.
- Latency: done is high in the cycle beginning two rising edges after the edge that captured the last byte.
- abort=1 in COLLECT or EVAL: go to IDLE next edge, check=0, counters retained for debug, no done.
  - abort has priority over en/last on the same cycle.
  - abort is ignored in IDLE and REPORT.
- start outside IDLE is ignored; start and abort together in IDLE means start wins.
- Counter outputs remain stable after REPORT until the next start.
- All counters are 6 bits; MAX_LEN<=63 guarantees they never wrap.

Optional Feature:
- Macro: PASS_SYMBOL_RULE_EN.
- Defined:
  - Adds parameter MIN_SYMS (default 1).
  - sym_cnt counts symbols as defined on the port.
  - The pass condition additionally requires sym_cnt>=MIN_SYMS.
- Undefined:
  - sym_cnt is tied to 0.
  - Symbols count in length only.
  - No symbol rule is applied.

Test Plan:
- Reset, then start, then stream "Pass1word" (last on 'd') -> length=9, vowel_cnt=2, cons_cnt=6, digit_cnt=1, done pulses exactly 2 edges after 'd', check=1, err=0 (PASS_SYMBOL_RULE_EN undefined).
- Stream "abc12" -> length=5<8, done pulses, check=0, err=0; then start again -> check clears to 0 and counters clear to 0 on the next edge.
- Stream 33 bytes 'a' with MAX_LEN=32 -> length=32, err=1 on the 33rd byte, check=0 after done.
- Stream "Pass" then a byte 0x07, then "word1" -> err=1, length=9, check=0; stream "Pass" then abort together with en&last -> busy drops next cycle, no done pulse, check=0.
- Drive reset low in the middle of the 5th byte -> all outputs 0 immediately, state IDLE; start without reset release has no effect.
- With PASS_SYMBOL_RULE_EN defined: "Pass1word" -> check=0, sym_cnt=0; "Pass1word!" -> check=1, sym_cnt=1, length=10.
